// File: rtl/md_unit_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO, sitting in E beside the ALU.
// Optional build macro MDU_DIV0_GUARD_EN: divide-by-zero finishes in one busy cycle, HI/LO untouched.
//
// state | meaning
// IDLE  | no op in flight; accepts mult/div, mthi/mtlo write directly
// BUSY  | op in flight; counter runs down, commit pending {hi,lo} at count 1
module md_unit_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op_E,
   input  logic [31:0] srcA_E,
   input  logic [31:0] srcB_E,
   input  logic        md_use_D,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata_E
);

   localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MaxCycles + 1);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMfhi  = 4'd7;
   localparam logic [3:0] OpMflo  = 4'd8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

   mdState_t        stateQ, stateD;
   logic [CW-1:0]   cntQ, cntD;
   logic [63:0]     pendQ, pendD;
   logic            pendValidQ, pendValidD;
   logic [31:0]     hiQ, hiD, loQ, loD;

   logic [63:0]     result;
   logic            isDivOp;
   logic            divByZero;
   logic [63:0]     prodSigned, prodUnsigned;
   logic [31:0]     absA, absB, magQ, magR, sQuot, sRem;

   assign isDivOp   = (md_op_E == OpDiv) || (md_op_E == OpDivu);
   assign divByZero = (srcB_E == 32'd0);

   assign start      = (stateQ == IDLE) && (md_op_E >= OpMult) && (md_op_E <= OpDivu);
   assign busy       = (stateQ == BUSY);
   assign stall_md   = md_use_D & (start | busy);
   assign hi         = hiQ;
   assign lo         = loQ;
   assign md_rdata_E = (md_op_E == OpMfhi) ? hiQ :
                       (md_op_E == OpMflo) ? loQ : 32'd0;

   // Signed divide on magnitudes; quotient sign from operand signs, remainder sign from dividend.
   always_comb begin
      prodSigned   = {{32{srcA_E[31]}}, srcA_E} * {{32{srcB_E[31]}}, srcB_E};
      prodUnsigned = {32'd0, srcA_E} * {32'd0, srcB_E};
      absA   = srcA_E[31] ? (~srcA_E + 32'd1) : srcA_E;
      absB   = srcB_E[31] ? (~srcB_E + 32'd1) : srcB_E;
      magQ   = divByZero ? 32'd0 : absA / absB;
      magR   = divByZero ? 32'd0 : absA % absB;
      sQuot  = (srcA_E[31] ^ srcB_E[31]) ? (~magQ + 32'd1) : magQ;
      sRem   = srcA_E[31] ? (~magR + 32'd1) : magR;
      result = 64'd0;
      case (md_op_E)
         OpMult:  result = prodSigned;
         OpMultu: result = prodUnsigned;
         OpDiv:   result = divByZero ? {srcA_E, (srcA_E[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)}
                                     : {sRem, sQuot};
         OpDivu:  result = divByZero ? {srcA_E, 32'hFFFF_FFFF}
                                     : {srcA_E % srcB_E, srcA_E / srcB_E};
         default: result = 64'd0;
      endcase
   end

   always_comb begin
      stateD     = stateQ;
      cntD       = cntQ;
      pendD      = pendQ;
      pendValidD = pendValidQ;
      hiD        = hiQ;
      loD        = loQ;
      case (stateQ)
         IDLE: begin
            if (start) begin
               pendD      = result;
               pendValidD = 1'b1;
               cntD       = isDivOp ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
`ifdef MDU_DIV0_GUARD_EN
               if (isDivOp && divByZero) begin
                  cntD       = CW'(1);
                  pendValidD = 1'b0;
               end
`endif
               stateD = BUSY;
            end else if (md_op_E == OpMthi) begin
               hiD = srcA_E;
            end else if (md_op_E == OpMtlo) begin
               loD = srcA_E;
            end
         end
         BUSY: begin
            cntD = cntQ - CW'(1);
            if (cntQ == CW'(1)) begin
               if (pendValidQ) begin
                  hiD = pendQ[63:32];
                  loD = pendQ[31:0];
               end
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ     <= IDLE;
         cntQ       <= '0;
         pendQ      <= 64'd0;
         pendValidQ <= 1'b0;
         hiQ        <= 32'd0;
         loQ        <= 32'd0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         pendQ      <= pendD;
         pendValidQ <= pendValidD;
         hiQ        <= hiD;
         loQ        <= loD;
      end
   end

endmodule

// File: tb/tb_md_unit_sequencer.sv
// Directed self-checking bench for md_unit_sequencer (default MULT_CYCLES=5, DIV_CYCLES=10).
// Build with MDU_DIV0_GUARD_EN defined to check the one-cycle divide-by-zero variant.
module tb_md_unit_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  md_op_E;
   logic [31:0] srcA_E, srcB_E;
   logic        md_use_D;
   logic        start, busy, stall_md;
   logic [31:0] hi, lo, md_rdata_E;

   int checks = 0;
   int errors = 0;

   md_unit_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op_E(md_op_E), .srcA_E(srcA_E), .srcB_E(srcB_E),
      .md_use_D(md_use_D), .start(start), .busy(busy), .stall_md(stall_md),
      .hi(hi), .lo(lo), .md_rdata_E(md_rdata_E)
   );

   always #5 clk = ~clk;

   // The pipeline must never present a write/start op to a busy unit.
   always @(negedge clk) begin
      if (!reset && busy && md_op_E >= 4'd1 && md_op_E <= 4'd6) begin
         errors++;
         $display("FAIL illegal_op_while_busy: op=%0d", md_op_E);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one op for a cycle, then count busy cycles; returns in the first idle cycle.
   task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int nBusy, output logic startSeen);
      md_op_E = op; srcA_E = a; srcB_E = b;
      #1;
      startSeen = start;
      tick();
      md_op_E = 4'd0;
      nBusy = 0;
      while (busy && nBusy < 40) begin
         nBusy++;
         tick();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; md_op_E = 4'd0; srcA_E = 32'd0; srcB_E = 32'd0; md_use_D = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0 || start !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b hi=%h lo=%h stall=%b start=%b, required all zero",
                  busy, hi, lo, stall_md, start);
      end
   endtask

   task automatic test_mult;
      int n; logic s;
      issue_op(4'd1, 32'hFFFF_FFFE, 32'd3, n, s);
      checks++;
      if (s !== 1'b1) begin errors++; $display("FAIL mult_start: got %b required 1", s); end
      checks++;
      if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d required 5", n); end
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL mult_result: got %h_%h required ffffffff_fffffffa", hi, lo);
      end
      // back-to-back multu issued in the first idle cycle
      issue_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, s);
      checks++;
      if (s !== 1'b1 || n !== 5 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_b2b: start=%b busy=%0d result=%h_%h required 1 5 fffffffe_00000001",
                  s, n, hi, lo);
      end
   endtask

   task automatic test_div;
      int n; logic s;
      issue_op(4'd4, 32'd100, 32'd7, n, s);
      checks++;
      if (n !== 10 || lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_100_7: busy=%0d lo=%0d hi=%0d required 10 14 2", n, lo, hi);
      end
      issue_op(4'd3, 32'hFFFF_FFF9, 32'd2, n, s);
      checks++;
      if (n !== 10 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_m7_2: busy=%0d lo=%h hi=%h required 10 fffffffd ffffffff", n, lo, hi);
      end
      issue_op(4'd3, 32'd7, 32'hFFFF_FFFE, n, s);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
         errors++;
         $display("FAIL div_7_m2: lo=%h hi=%h required fffffffd 00000001", lo, hi);
      end
      issue_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, s);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         errors++;
         $display("FAIL div_overflow: lo=%h hi=%h required 80000000 00000000", lo, hi);
      end
   endtask

   task automatic test_stall;
      int cnt;
      md_use_D = 1'b1; md_op_E = 4'd0;
      #1;
      checks++;
      if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b required 0", stall_md); end
      md_op_E = 4'd1; srcA_E = 32'd2; srcB_E = 32'd3;
      #1;
      cnt = 0;
      while (stall_md === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
         md_op_E = 4'd0;
         #1;
      end
      checks++;
      if (cnt !== 6) begin errors++; $display("FAIL stall_cycles: got %0d required 6", cnt); end
      checks++;
      if (busy !== 1'b0 || lo !== 32'd6) begin
         errors++;
         $display("FAIL stall_drop_commit: busy=%b lo=%0d required 0 6", busy, lo);
      end
      md_use_D = 1'b0;
   endtask

   task automatic test_move;
      md_op_E = 4'd5; srcA_E = 32'h1234_5678;
      #1;
      checks++;
      if (start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %b required 0", start); end
      tick();
      md_op_E = 4'd6; srcA_E = 32'hCAFE_BABE;
      checks++;
      if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mthi: hi=%h busy=%b required 12345678 0", hi, busy);
      end
      tick();
      md_op_E = 4'd8;
      #1;
      checks++;
      if (lo !== 32'hCAFE_BABE || md_rdata_E !== 32'hCAFE_BABE) begin
         errors++;
         $display("FAIL mtlo_mflo: lo=%h rdata=%h required cafebabe", lo, md_rdata_E);
      end
      md_op_E = 4'd7;
      #1;
      checks++;
      if (md_rdata_E !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mfhi: got %h required 12345678", md_rdata_E);
      end
      md_op_E = 4'd0;
      #1;
      checks++;
      if (md_rdata_E !== 32'd0) begin errors++; $display("FAIL rdata_none: got %h required 0", md_rdata_E); end
   endtask

   task automatic test_reset_abort;
      md_op_E = 4'd4; srcA_E = 32'd100; srcB_E = 32'd7;
      tick();
      md_op_E = 4'd0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
      end
      repeat (12) tick();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
      end
   endtask

   task automatic test_div0;
      int n; logic s;
      logic [31:0] oldHi, oldLo;
      md_op_E = 4'd5; srcA_E = 32'h0000_0AAA;
      tick();
      md_op_E = 4'd6; srcA_E = 32'h0000_0555;
      tick();
      oldHi = 32'h0000_0AAA; oldLo = 32'h0000_0555;
      issue_op(4'd4, 32'd9, 32'd0, n, s);
`ifdef MDU_DIV0_GUARD_EN
      checks++;
      if (n !== 1 || hi !== oldHi || lo !== oldLo) begin
         errors++;
         $display("FAIL divu_zero_guard: busy=%0d hi=%h lo=%h required 1 %h %h", n, hi, lo, oldHi, oldLo);
      end
      issue_op(4'd3, 32'hFFFF_FFFB, 32'd0, n, s);
      checks++;
      if (n !== 1 || hi !== oldHi || lo !== oldLo) begin
         errors++;
         $display("FAIL div_zero_guard: busy=%0d hi=%h lo=%h required 1 %h %h", n, hi, lo, oldHi, oldLo);
      end
`else
      checks++;
      if (n !== 10 || hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL divu_zero: busy=%0d hi=%h lo=%h required 10 00000009 ffffffff", n, hi, lo);
      end
      issue_op(4'd3, 32'hFFFF_FFFB, 32'd0, n, s);
      checks++;
      if (n !== 10 || hi !== 32'hFFFF_FFFB || lo !== 32'd1) begin
         errors++;
         $display("FAIL div_zero_neg: busy=%0d hi=%h lo=%h required 10 fffffffb 00000001", n, hi, lo);
      end
      issue_op(4'd3, 32'd9, 32'd0, n, s);
      checks++;
      if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_zero_pos: hi=%h lo=%h required 00000009 ffffffff", hi, lo);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_stall();
      test_move();
      test_reset_abort();
      test_div0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
